// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the traffic phase controller.
//   phase_t     : six-state phase encoding (also driven on the phase port)
//   light_t     : per-direction lamp encoding (RED/YEL/GRN; 2'b11 unused)
//   DEF_WIDTH   : default vehicle-count width
//   timer_width : sizes the phase timer for the longest phase duration
// -----------------------------------------------------------------------------
package traffic_pkg;

   localparam int DEF_WIDTH = 9;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      RED_A = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      RED_B = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      RED = 2'b00,
      YEL = 2'b01,
      GRN = 2'b10
   } light_t;

   // One bit more than strictly needed so the saturated all-ones value is
   // always at or above every "last tick" threshold.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 1) m = 1;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/vehicle_counter.sv
// -----------------------------------------------------------------------------
// vehicle_counter
// Counts rising edges of a synchronous sensor level into a saturating counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   car   : sensor level; each 0->1 transition counts one vehicle
//   clr   : clear request (phase entry of the owning green)
//   cnt   : queued-vehicle count, saturates at all-ones
// A clear that coincides with an arrival leaves the count at 1 so the
// arriving vehicle is not lost.
// -----------------------------------------------------------------------------
module vehicle_counter
   import traffic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             car,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic             prev_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             rise;

   assign rise = car & ~prev_reg;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = rise ? WIDTH'(1) : '0;
      end else if (rise && (cnt_reg != '1)) begin
         cnt_next = cnt_reg + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         prev_reg <= car;
         cnt_reg  <= cnt_next;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Two-direction intersection phase controller with vehicle queue counters.
// Phase cycle: NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B -> NS_G.
// A green is held past GREEN_CYC while the opposing queue is empty.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick              : one-cycle timebase enable
//   car_ns, car_ew    : vehicle sensor levels (rising edge = one vehicle)
//   cnt_ns, cnt_ew    : queued-vehicle counts (selector data_in0/data_in1)
//   sel               : selector control, 1 = cnt_ew, 0 = cnt_ns
//   light_ns/light_ew : 00 red, 01 yellow, 10 green
//   phase             : current phase encoding
//
// Build option: define TRAFFIC_EARLY_SWITCH_EN to let a green end early once
// MIN_GREEN ticks have elapsed and the opposing queue has reached THRESH.
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GREEN_CYC  = 20,
   parameter int YELLOW_CYC = 4,
   parameter int RED_CYC    = 2,
   parameter int MIN_GREEN  = 8,
   parameter int THRESH     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             car_ns,
   input  logic             car_ew,
   output logic [WIDTH-1:0] cnt_ns,
   output logic [WIDTH-1:0] cnt_ew,
   output logic             sel,
   output logic [1:0]       light_ns,
   output logic [1:0]       light_ew,
   output logic [2:0]       phase
);

   localparam int TW = timer_width(GREEN_CYC, YELLOW_CYC, RED_CYC);

   localparam logic [TW-1:0] G_LAST = TW'(GREEN_CYC - 1);
   localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] R_LAST = TW'(RED_CYC - 1);

   // Elaboration-time guard on the timing parameters.
   if (GREEN_CYC < 1 || YELLOW_CYC < 1 || RED_CYC < 1 ||
       MIN_GREEN < 1 || MIN_GREEN > GREEN_CYC || THRESH < 1) begin : g_bad_cfg
      $error("traffic_phase_ctrl: invalid timing parameters");
   end

   phase_t           state_reg,    state_next;
   logic [TW-1:0]    timer_reg,    timer_next;
   logic             sel_reg,      sel_next;
   light_t           light_ns_reg, light_ns_next;
   light_t           light_ew_reg, light_ew_next;

   logic [WIDTH-1:0] opp_cnt;
   logic             green_done;
   logic             clr_ns, clr_ew;

   logic [1:0]       car_vec;
   logic [1:0]       clr_vec;
   logic [WIDTH-1:0] cnt_vec [2];

   // ---------------------------------------------------------------------
   // Queue counters: index 0 = north-south, index 1 = east-west
   // ---------------------------------------------------------------------
   assign car_vec = {car_ew, car_ns};
   assign clr_vec = {clr_ew, clr_ns};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      vehicle_counter #(
         .WIDTH (WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .car   (car_vec[gi]),
         .clr   (clr_vec[gi]),
         .cnt   (cnt_vec[gi])
      );
   end

   assign cnt_ns = cnt_vec[0];
   assign cnt_ew = cnt_vec[1];

   // ---------------------------------------------------------------------
   // Green exit decision
   // ---------------------------------------------------------------------
`ifdef TRAFFIC_EARLY_SWITCH_EN
   localparam logic [TW-1:0]    MIN_LAST = TW'(MIN_GREEN - 1);
   localparam logic [WIDTH-1:0] THR      = WIDTH'(THRESH);
`endif

   always_comb begin
      opp_cnt = '0;
      case (state_reg)
         NS_G:    opp_cnt = cnt_ew;
         EW_G:    opp_cnt = cnt_ns;
         default: opp_cnt = '0;
      endcase

      // The timer saturates rather than wraps, so once the nominal green has
      // run out it stays at or above G_LAST for the whole no-demand hold.
      green_done = (timer_reg >= G_LAST) && (opp_cnt != '0);
`ifdef TRAFFIC_EARLY_SWITCH_EN
      if ((timer_reg >= MIN_LAST) && (opp_cnt >= THR)) begin
         green_done = 1'b1;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // Next-state, timer and registered-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      sel_next      = sel_reg;
      light_ns_next = RED;
      light_ew_next = RED;
      clr_ns        = 1'b0;
      clr_ew        = 1'b0;

      case (state_reg)
         NS_G:    if (tick && green_done)             state_next = NS_Y;
         NS_Y:    if (tick && (timer_reg == Y_LAST))  state_next = RED_A;
         RED_A:   if (tick && (timer_reg == R_LAST))  state_next = EW_G;
         EW_G:    if (tick && green_done)             state_next = EW_Y;
         EW_Y:    if (tick && (timer_reg == Y_LAST))  state_next = RED_B;
         RED_B:   if (tick && (timer_reg == R_LAST))  state_next = NS_G;
         default:                                     state_next = RED_B;
      endcase

      if (state_next != state_reg) begin
         timer_next = '0;
      end else if (tick && (timer_reg != '1)) begin
         timer_next = timer_reg + TW'(1);
      end

      clr_ns = (state_next == NS_G) && (state_reg != NS_G);
      clr_ew = (state_next == EW_G) && (state_reg != EW_G);

      // Outputs are decoded from the next state so they change on the same
      // edge as phase.
      case (state_next)
         NS_G:    begin sel_next = 1'b1; light_ns_next = GRN; end
         NS_Y:    begin sel_next = 1'b1; light_ns_next = YEL; end
         RED_A:   begin sel_next = 1'b1;                      end
         EW_G:    begin sel_next = 1'b0; light_ew_next = GRN; end
         EW_Y:    begin sel_next = 1'b0; light_ew_next = YEL; end
         default: begin sel_next = 1'b0;                      end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= RED_B;
         timer_reg    <= '0;
         sel_reg      <= 1'b0;
         light_ns_reg <= RED;
         light_ew_reg <= RED;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         sel_reg      <= sel_next;
         light_ns_reg <= light_ns_next;
         light_ew_reg <= light_ew_next;
      end
   end

   assign phase    = state_reg;
   assign sel      = sel_reg;
   assign light_ns = light_ns_reg;
   assign light_ew = light_ew_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_ctrl
// Directed bench for traffic_phase_ctrl with default parameters.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

   localparam int WIDTH = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tick;
   logic             car_ns;
   logic             car_ew;
   logic [WIDTH-1:0] cnt_ns;
   logic [WIDTH-1:0] cnt_ew;
   logic             sel;
   logic [1:0]       light_ns;
   logic [1:0]       light_ew;
   logic [2:0]       phase;

   int total = 0;
   int bad   = 0;
   int len;

   traffic_phase_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .car_ns   (car_ns),
      .car_ew   (car_ew),
      .cnt_ns   (cnt_ns),
      .cnt_ew   (cnt_ew),
      .sel      (sel),
      .light_ns (light_ns),
      .light_ew (light_ew),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(input int p);
      int n;
      n = 0;
      while (int'(phase) != p && n < 400) begin
         step();
         n++;
      end
      if (int'(phase) != p) chk("wait_phase_timeout", int'(phase), p);
   endtask

   task automatic phase_len(input int p, output int n);
      n = 0;
      while (int'(phase) == p && n < 400) begin
         n++;
         step();
      end
   endtask

   task automatic pulse_ns();
      car_ns = 1'b1;
      step();
      car_ns = 1'b0;
      step();
   endtask

   task automatic pulse_ew();
      car_ew = 1'b1;
      step();
      car_ew = 1'b0;
      step();
   endtask

   initial begin
      rst_n  = 1'b0;
      tick   = 1'b0;
      car_ns = 1'b0;
      car_ew = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_phase",  int'(phase), 5);
      chk("rst_cnt_ns", int'(cnt_ns), 0);
      chk("rst_cnt_ew", int'(cnt_ew), 0);
      chk("rst_sel",    int'(sel), 0);
      chk("rst_lights", int'({light_ns, light_ew}), 0);

      // Release: RED_B lasts RED_CYC ticks, then NS_G
      tick  = 1'b1;
      rst_n = 1'b1;
      phase_len(5, len);
      chk("rel_red_b_len", len, 2);

      // Full cycle, one car_ew pulse during NS_G
      chk("ns_g_phase",  int'(phase), 0);
      chk("ns_g_sel",    int'(sel), 1);
      chk("ns_g_lights", int'({light_ns, light_ew}), 4'b1000);
      len = 0;
      while (int'(phase) == 0 && len < 400) begin
         car_ew = (len == 3);
         len++;
         step();
      end
      car_ew = 1'b0;
      chk("ns_g_len",    len, 20);
      chk("ns_y_lights", int'({light_ns, light_ew}), 4'b0100);
      chk("ns_y_sel",    int'(sel), 1);
      phase_len(1, len);
      chk("ns_y_len",    len, 4);
      chk("red_a_lights", int'({light_ns, light_ew}), 0);
      chk("red_a_cnt_ew", int'(cnt_ew), 1);
      phase_len(2, len);
      chk("red_a_len",   len, 2);
      chk("ew_g_phase",  int'(phase), 3);
      chk("ew_g_cnt_ew", int'(cnt_ew), 0);
      chk("ew_g_sel",    int'(sel), 0);
      chk("ew_g_lights", int'({light_ns, light_ew}), 4'b0010);

      // Saturation with the timebase frozen in EW_G
      tick = 1'b0;
      repeat (300) pulse_ns();
      chk("sat_cnt_300", int'(cnt_ns), 300);
      repeat (300) pulse_ns();
      chk("sat_cnt_600", int'(cnt_ns), 511);
      repeat (5) pulse_ns();
      chk("sat_hold",    int'(cnt_ns), 511);
      chk("sat_phase",   int'(phase), 3);

      // No-demand hold in NS_G
      tick = 1'b1;
      wait_phase(0);
      chk("hold_cnt_ns_clr", int'(cnt_ns), 0);
      chk("hold_cnt_ew",     int'(cnt_ew), 0);
      repeat (50) step();
      chk("hold_50_phase", int'(phase), 0);
      car_ew = 1'b1;
      step();
      car_ew = 1'b0;
      chk("hold_edge_phase",  int'(phase), 0);
      chk("hold_edge_cnt_ew", int'(cnt_ew), 1);
      step();
      chk("hold_exit_phase",  int'(phase), 1);

      // Coincident clear and arrival on EW_G entry
      wait_phase(2);
      step();
      chk("coin_pre_phase", int'(phase), 2);
      car_ew = 1'b1;
      step();
      car_ew = 1'b0;
      chk("coin_phase",  int'(phase), 3);
      chk("coin_cnt_ew", int'(cnt_ew), 1);

      // Early switch: queue 16 more EW cars at the start of NS_G
      pulse_ns();
      wait_phase(0);
      tick = 1'b0;
      chk("early_cnt_ew0", int'(cnt_ew), 1);
      repeat (16) pulse_ew();
      chk("early_cnt_ew", int'(cnt_ew), 17);
      tick = 1'b1;
      phase_len(0, len);
`ifdef TRAFFIC_EARLY_SWITCH_EN
      chk("early_ns_g_len", len, 8);
`else
      chk("early_ns_g_len", len, 20);
`endif
      chk("early_next_phase", int'(phase), 1);

      // Asynchronous reset mid-EW_G
      wait_phase(3);
      car_ns = 1'b1;
      car_ew = 1'b1;
      step();
      car_ns = 1'b0;
      car_ew = 1'b0;
      step();
      chk("mid_pre_phase",  int'(phase), 3);
      chk("mid_pre_cnt_ns", int'(cnt_ns), 1);
      chk("mid_pre_cnt_ew", int'(cnt_ew), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_phase",  int'(phase), 5);
      chk("mid_rst_cnt_ns", int'(cnt_ns), 0);
      chk("mid_rst_cnt_ew", int'(cnt_ew), 0);
      chk("mid_rst_sel",    int'(sel), 0);
      chk("mid_rst_lights", int'({light_ns, light_ew}), 0);
      step();
      rst_n = 1'b1;
      phase_len(5, len);
      chk("mid_rel_red_b_len", len, 2);
      chk("mid_rel_phase",     int'(phase), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
